// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and helpers for the pipeline hazard/forwarding controller
package pipeline_pkg;

    // Stage records hold register addresses at this width; ADDRESS_WIDTH must not exceed it.
    localparam int REG_ADDR_W = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      regwrite;
        logic      memread;
    } ex_rec_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      regwrite;
        logic      memread;
    } mem_rec_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      regwrite;
    } wb_rec_t;

    // True when a stage will write register r; x0 is never a real destination.
    function automatic logic stage_writes(input logic valid, input logic regwrite,
                                          input reg_addr_t rd, input reg_addr_t r);
        return valid && regwrite && (r != '0) && (rd == r);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - operand forwarding select for one EX source register
module fwd_unit
    import pipeline_pkg::*;
(
    input  reg_addr_t src,
    input  mem_rec_t  mem,
    input  wb_rec_t   wb,
    output fwd_sel_t  sel
);

    // EX/MEM result wins over MEM/WB; a load still in MEM has no data to forward yet.
    always_comb begin
        sel = FWD_REG;
        if (stage_writes(mem.valid, mem.regwrite, mem.rd, src) && !mem.memread) begin
            sel = FWD_MEM;
        end else if (stage_writes(wb.valid, wb.regwrite, wb.rd, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, flush and forwarding control for the 5-stage core (option macro: PIPELINE_FWD_EN)
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid,
    input  logic [ADDRESS_WIDTH-1:0] id_rs1,
    input  logic [ADDRESS_WIDTH-1:0] id_rs2,
    input  logic                     id_uses_rs1,
    input  logic                     id_uses_rs2,
    input  logic [ADDRESS_WIDTH-1:0] id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     ex_branch_taken,
    output logic                     pc_en,
    output logic                     ifid_en,
    output logic                     ifid_flush,
    output logic                     idex_flush,
    output logic [1:0]               fwd_a,
    output logic [1:0]               fwd_b,
    output logic                     ex_valid,
    output logic                     mem_valid,
    output logic                     wb_valid,
    output logic                     wb_regwrite,
    output logic [CNT_WIDTH-1:0]     stall_cycles,
    output logic [CNT_WIDTH-1:0]     flush_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic      id_valid;
    ex_rec_t   ex_q;
    mem_rec_t  mem_q;
    wb_rec_t   wb_q;

    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      stall;
    logic      flush;
    logic      ex_hit;

    assign rs1 = reg_addr_t'(id_rs1);
    assign rs2 = reg_addr_t'(id_rs2);
    assign rd  = reg_addr_t'(id_rd);

    assign ex_hit = (id_uses_rs1 && stage_writes(ex_q.valid, ex_q.regwrite, ex_q.rd, rs1)) ||
                    (id_uses_rs2 && stage_writes(ex_q.valid, ex_q.regwrite, ex_q.rd, rs2));

`ifdef PIPELINE_FWD_EN
    // Only a load in EX cannot be covered by forwarding.
    assign stall = ex_hit && ex_q.memread;
`else
    logic mem_hit;
    logic wb_hit;
    logic unused_fwd_fields;

    assign mem_hit = (id_uses_rs1 && stage_writes(mem_q.valid, mem_q.regwrite, mem_q.rd, rs1)) ||
                     (id_uses_rs2 && stage_writes(mem_q.valid, mem_q.regwrite, mem_q.rd, rs2));
    assign wb_hit  = (id_uses_rs1 && stage_writes(wb_q.valid, wb_q.regwrite, wb_q.rd, rs1)) ||
                     (id_uses_rs2 && stage_writes(wb_q.valid, wb_q.regwrite, wb_q.rd, rs2));

    // No bypass and no regfile write-through: wait until the producer has left WB.
    assign stall = ex_hit || mem_hit || wb_hit;
    assign unused_fwd_fields = ^{ex_q.rs1, ex_q.rs2, mem_q.memread};
`endif

    assign flush       = ex_branch_taken;
    assign pc_en       = !stall || flush;
    assign ifid_en     = !stall;
    assign ifid_flush  = flush;
    assign idex_flush  = stall || flush;

    assign ex_valid    = ex_q.valid;
    assign mem_valid   = mem_q.valid;
    assign wb_valid    = wb_q.valid;
    assign wb_regwrite = wb_q.valid && wb_q.regwrite;

`ifdef PIPELINE_FWD_EN
    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    fwd_unit u_fwd_a (.src(ex_q.rs1), .mem(mem_q), .wb(wb_q), .sel(sel_a));
    fwd_unit u_fwd_b (.src(ex_q.rs2), .mem(mem_q), .wb(wb_q), .sel(sel_b));

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;
`else
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    // Advance the per-stage records; a bubble or flush only clears the EX valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
        end else begin
            wb_q  <= '{valid: mem_q.valid, rd: mem_q.rd, regwrite: mem_q.regwrite};
            mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite,
                       memread: ex_q.memread};
            ex_q  <= '{valid: id_valid && !idex_flush, rs1: rs1, rs2: rs2, rd: rd,
                       regwrite: id_regwrite, memread: id_memread};
            if (flush) begin
                id_valid <= 1'b0;
            end else if (!stall) begin
                id_valid <= fetch_valid;
            end
        end
    end

    // Saturating stall/flush counters; a stall hidden by a flush is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && !flush && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
            if (flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
